// File: rtl/test_vec_if.sv
// ----------------------------------------------------------------------------
// test_vec_if
// Vector/response channel between the test vector driver and the checker.
//   out_valid     : driver presents a vector
//   out_ready     : checker accepts the vector
//   out_a, out_b  : operands
//   out_test_flag : test flag sent with the vector
//   rsp_valid     : checker response strobe
//   rsp_adr_valid : checker verdict, 1 when a != b
//   rsp_err       : checker error flag
// Modports: master = driver side, slave = checker side.
// ----------------------------------------------------------------------------
interface test_vec_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_test_flag;
    logic        rsp_valid;
    logic        rsp_adr_valid;
    logic        rsp_err;

    modport master (
        output out_valid, out_a, out_b, out_test_flag,
        input  out_ready, rsp_valid, rsp_adr_valid, rsp_err
    );

    modport slave (
        input  out_valid, out_a, out_b, out_test_flag,
        output out_ready, rsp_valid, rsp_adr_valid, rsp_err
    );
endinterface

// File: rtl/test_vec_driver.sv
// ----------------------------------------------------------------------------
// test_vec_driver
// Drives a run of LFSR-generated operand pairs to a comparator checker, one
// vector outstanding at a time, and counts verdict mismatches and errors.
//
// Ports:
//   clk, rst_n     : clock (rising edge), synchronous active-low reset
//   start          : launch pulse, honoured only in IDLE or DONE
//   num_vecs       : vectors in the run (sampled on start)
//   seed           : LFSR seed, 0 maps to 1 (sampled on start)
//   test_mode      : flag sent with every vector (sampled on start)
//   vec            : test_vec_if.master vector/response channel
//   busy           : run in progress (SEND or WAIT_RSP)
//   done           : one-cycle pulse on entry to DONE
//   mismatch_cnt   : responses whose verdict differs from the expected one
//   err_cnt        : responses with rsp_err set, plus timeouts
//
// Build option: define TVD_RSP_TIMEOUT_EN to add a response timeout of
// TIMEOUT cycles in WAIT_RSP; without it WAIT_RSP waits indefinitely.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// SEND     | vector presented, waiting for out_ready
// WAIT_RSP | vector accepted, waiting for the checker response
// DONE     | run finished, counters hold until next start
// ----------------------------------------------------------------------------
module test_vec_driver #(
    parameter int SAME_EVERY = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_vecs,
    input  logic [31:0] seed,
    input  logic        test_mode,
    test_vec_if.master  vec,
    output logic        busy,
    output logic        done,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] err_cnt
);
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
    localparam logic [15:0] PHASE_LAST = 16'(SAME_EVERY - 1);

    if (SAME_EVERY < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("test_vec_driver: SAME_EVERY and TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
    state_t state, state_nx;

    logic [31:0] lfsr;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [15:0] idx;
    logic [15:0] phase;      // idx mod SAME_EVERY, kept as a wrapping counter
    logic [15:0] num_q;
    logic        flag_q;
    logic        exp_verdict;
    logic        done_q;

    logic        start_ok;
    logic        accept;
    logic        rsp_hit;
    logic        tmo_hit;
    logic        rsp_evt;
    logic        last_vec;
    logic [31:0] seed_eff;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [31:0] pick_b(input logic [31:0] a, input logic [15:0] ph);
        return (ph == PHASE_LAST) ? a : ~a;
    endfunction

    assign start_ok = start && (state == IDLE || state == DONE);
    assign accept   = (state == SEND) && vec.out_ready;
    assign rsp_hit  = (state == WAIT_RSP) && vec.rsp_valid;
    assign rsp_evt  = rsp_hit || tmo_hit;
    // idx counts accepted vectors, so it already includes the one in flight
    assign last_vec = (idx >= num_q);
    assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

`ifdef TVD_RSP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Loaded on acceptance; reaches zero on the TIMEOUT-th WAIT_RSP cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= TMO_W'(TIMEOUT - 1);
        end else if (state == WAIT_RSP && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    // A response on the terminal cycle wins over the timeout.
    assign tmo_hit = (state == WAIT_RSP) && !vec.rsp_valid && (tmo_cnt == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nx = (num_vecs == 16'h0) ? DONE : SEND;
            SEND:       if (accept)   state_nx = WAIT_RSP;
            WAIT_RSP:   if (rsp_evt)  state_nx = last_vec ? DONE : SEND;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            lfsr         <= 32'h1;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            idx          <= 16'h0;
            phase        <= 16'h0;
            num_q        <= 16'h0;
            flag_q       <= 1'b0;
            exp_verdict  <= 1'b0;
            done_q       <= 1'b0;
            mismatch_cnt <= 16'h0;
            err_cnt      <= 16'h0;
        end else begin
            state  <= state_nx;
            // DONE re-entered via a zero-length start also pulses
            done_q <= (state_nx == DONE) && (state != DONE || start_ok);

            if (start_ok) begin
                num_q        <= num_vecs;
                flag_q       <= test_mode;
                lfsr         <= seed_eff;
                idx          <= 16'h0;
                phase        <= 16'h0;
                mismatch_cnt <= 16'h0;
                err_cnt      <= 16'h0;
                a_q          <= seed_eff;
                b_q          <= pick_b(seed_eff, 16'h0);
            end

            if (accept) begin
                lfsr        <= lfsr_step(lfsr);
                idx         <= idx + 16'd1;
                phase       <= (phase == PHASE_LAST) ? 16'h0 : phase + 16'd1;
                exp_verdict <= (a_q != b_q);
            end

            // lfsr and phase already advanced at acceptance
            if (rsp_evt && !last_vec) begin
                a_q <= lfsr;
                b_q <= pick_b(lfsr, phase);
            end

            if (rsp_hit && (vec.rsp_adr_valid != exp_verdict) && mismatch_cnt != 16'hFFFF) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end

            if (((rsp_hit && vec.rsp_err) || tmo_hit) && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign vec.out_valid     = (state == SEND);
    assign vec.out_a         = a_q;
    assign vec.out_b         = b_q;
    assign vec.out_test_flag = flag_q;
    assign busy              = (state == SEND) || (state == WAIT_RSP);
    assign done              = done_q;
endmodule

// File: tb/tb_test_vec_driver.sv
// ----------------------------------------------------------------------------
// tb_test_vec_driver
// Plays the checker side of test_vec_if. Inputs are driven and outputs
// sampled on the falling clock edge. Expected vectors come from the LFSR
// recurrence and the SAME_EVERY rule; expected counters from scoring each
// response the bench itself returns.
// ----------------------------------------------------------------------------
module tb_test_vec_driver;
    localparam int SE  = 4;
    localparam int TMO = 64;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [15:0] num_vecs  = 16'h0;
    logic [31:0] seed      = 32'h0;
    logic        test_mode = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_cnt;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;

    test_vec_if vif ();

    test_vec_driver #(.SAME_EVERY(SE), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_vecs     (num_vecs),
        .seed         (seed),
        .test_mode    (test_mode),
        .vec          (vif),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= 65535) ? 65535 : x + 1;
    endfunction

    // One complete run, checking every vector. Mode codes:
    // adr_mode 0 ideal, 1 always 1, 2 always 0, 3 random
    // err_mode 0 never, 1 odd responses, 2 always, 3 random
    task automatic run(input logic [15:0] n, input logic [31:0] sd, input logic tm,
                       input int adr_mode, input int err_mode,
                       input int stall_lo, input int stall_hi,
                       input int lat_lo, input int lat_hi, input bit noise,
                       input int poke_at, input int abort_at,
                       input int tmo_at, input int edge_at);
        logic [31:0] m_lfsr, ea, eb;
        logic        adr, err, verdict;
        int          mm, er, k, lat;
        m_lfsr = (sd == 32'h0) ? 32'h1 : sd;
        mm = 0;
        er = 0;
        start = 1'b1; num_vecs = n; seed = sd; test_mode = tm;
        @(negedge clk);
        start = 1'b0;
        if (n == 16'h0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_mm", mismatch_cnt, 0);
            chk("zero_err", err_cnt, 0);
            @(negedge clk);
            chk("zero_done_fall", done, 0);
            chk("zero_busy2", busy, 0);
            return;
        end
        for (int v = 0; v < int'(n); v++) begin
            ea = m_lfsr;
            eb = (v % SE == SE - 1) ? ea : ~ea;
            chk($sformatf("valid_v%0d", v), vif.out_valid, 1);
            chk($sformatf("busy_v%0d", v), busy, 1);
            k = int'($urandom_range(stall_hi, stall_lo));
            for (int j = 0; j < k; j++) begin
                vif.rsp_valid     = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                vif.rsp_err       = 1'b1;
                vif.rsp_adr_valid = 1'($urandom_range(1, 0));
                chk($sformatf("stall_a_v%0d", v), vif.out_a, ea);
                chk($sformatf("stall_b_v%0d", v), vif.out_b, eb);
                chk($sformatf("stall_flag_v%0d", v), vif.out_test_flag, tm);
                @(negedge clk);
                chk($sformatf("stall_valid_v%0d", v), vif.out_valid, 1);
            end
            chk($sformatf("a_v%0d", v), vif.out_a, ea);
            chk($sformatf("b_v%0d", v), vif.out_b, eb);
            chk($sformatf("flag_v%0d", v), vif.out_test_flag, tm);
            vif.out_ready = 1'b1;
            @(negedge clk);
            vif.out_ready = 1'b0;
            vif.rsp_valid = 1'b0;
            vif.rsp_err   = 1'b0;
            chk($sformatf("one_outstanding_v%0d", v), vif.out_valid, 0);
            m_lfsr = lfsr_step(m_lfsr);

            if (v == abort_at) begin
                chk("pre_abort_mm", mismatch_cnt, mm);
                chk("pre_abort_err", err_cnt, er);
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_valid", vif.out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_flag", vif.out_test_flag, 0);
                chk("abort_a", vif.out_a, 0);
                chk("abort_b", vif.out_b, 0);
                chk("abort_mm", mismatch_cnt, 0);
                chk("abort_err", err_cnt, 0);
                rst_n = 1'b1;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    chk("abort_quiet", {done, busy}, 0);
                end
                return;
            end

            if (v == poke_at) begin
                start = 1'b1; num_vecs = 16'd1; seed = 32'hDEAD_BEEF; test_mode = ~tm;
                @(negedge clk);
                start = 1'b0; num_vecs = n; seed = sd; test_mode = tm;
                chk("poke_busy", busy, 1);
            end

`ifdef TVD_RSP_TIMEOUT_EN
            if (v == tmo_at) begin
                for (int j = 0; j < TMO; j++) begin
                    chk("tmo_wait", vif.out_valid, 0);
                    @(negedge clk);
                end
                er = sat_inc(er);
                chk("tmo_err", err_cnt, er);
                chk("tmo_mm", mismatch_cnt, mm);
                continue;
            end
`endif

            lat = (v == edge_at) ? TMO - 1 : int'($urandom_range(lat_hi, lat_lo));
            repeat (lat) @(negedge clk);
            verdict = (ea != eb);
            case (adr_mode)
                0:       adr = verdict;
                1:       adr = 1'b1;
                2:       adr = 1'b0;
                default: adr = 1'($urandom_range(1, 0));
            endcase
            case (err_mode)
                0:       err = 1'b0;
                1:       err = (v % 2 == 1);
                2:       err = 1'b1;
                default: err = 1'($urandom_range(1, 0));
            endcase
            if (adr != verdict) mm = sat_inc(mm);
            if (err) er = sat_inc(er);
            vif.rsp_valid = 1'b1; vif.rsp_adr_valid = adr; vif.rsp_err = err;
            @(negedge clk);
            vif.rsp_valid = 1'b0; vif.rsp_adr_valid = 1'b0; vif.rsp_err = 1'b0;
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", vif.out_valid, 0);
        chk("end_mm", mismatch_cnt, mm);
        chk("end_err", err_cnt, er);
        @(negedge clk);
        chk("end_done_fall", done, 0);
        chk("hold_mm", mismatch_cnt, mm);
        chk("hold_err", err_cnt, er);
    endtask

    typedef struct {
        logic [15:0] n;
        logic [31:0] sd;
        logic        tm;
        int          adr;
        int          err;
        int          stall;
        int          poke;
        int          exp_mm;
        int          exp_err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{16'd4,  32'h0,         1'b0, 0, 0, 0, -1, 0, 0};
        tbl[1] = '{16'd3,  32'h0000_ACE1, 1'b1, 0, 0, 5, -1, 0, 0};
        tbl[2] = '{16'd8,  32'h1234_5678, 1'b0, 1, 1, 0, -1, 2, 4};
        tbl[3] = '{16'd0,  32'h0000_0077, 1'b1, 0, 0, 0, -1, 0, 0};
        tbl[4] = '{16'd8,  32'hCAFE_F00D, 1'b1, 2, 0, 1, -1, 6, 0};
        tbl[5] = '{16'd5,  32'h0000_0003, 1'b0, 0, 2, 0, -1, 0, 5};
        tbl[6] = '{16'd12, 32'h8000_0000, 1'b0, 1, 2, 2, -1, 3, 12};
        tbl[7] = '{16'd1,  32'h0BAD_F00D, 1'b1, 1, 0, 0, -1, 0, 0};
        tbl[8] = '{16'd3,  32'h0000_1111, 1'b0, 0, 0, 0,  1, 0, 0};

        vif.out_ready = 1'b0; vif.rsp_valid = 1'b0;
        vif.rsp_adr_valid = 1'b0; vif.rsp_err = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", vif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flag", vif.out_test_flag, 0);
        chk("rst_a", vif.out_a, 0);
        chk("rst_b", vif.out_b, 0);
        chk("rst_mm", mismatch_cnt, 0);
        chk("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Seed 0 run must open with the 32'h1 state
        start = 1'b1; num_vecs = 16'd2; seed = 32'h0; test_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("first_a_seed0", vif.out_a, 32'h1);
        chk("first_b_seed0", vif.out_b, 32'hFFFF_FFFE);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].n, tbl[i].sd, tbl[i].tm, tbl[i].adr, tbl[i].err,
                tbl[i].stall, tbl[i].stall, 0, 2, 1'b0, tbl[i].poke, -1, -1, -1);
            chk($sformatf("tbl%0d_mm", i), mismatch_cnt, tbl[i].exp_mm);
            chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].exp_err);
        end

        // Reset while waiting for the response to vector 3 of 10
        run(16'd10, 32'h5A5A_0001, 1'b1, 2, 2, 0, 1, 0, 2, 1'b0, -1, 2, -1, -1);

        for (int r = 0; r < 6; r++) begin
            run(16'($urandom_range(12, 1)), $urandom, 1'($urandom_range(1, 0)),
                3, 3, 0, 3, 0, 4, 1'b1, -1, -1, -1, -1);
        end

`ifdef TVD_RSP_TIMEOUT_EN
        // Vector 0 times out, vector 1 answers on the timeout cycle
        run(16'd3, 32'h0000_0005, 1'b0, 0, 0, 0, 0, 0, 1, 1'b0, -1, -1, 0, 1);
        chk("tmo_total_mm", mismatch_cnt, 0);
        chk("tmo_total_err", err_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
